// File: rtl/usart_rx_buffer.sv
// Receive buffer behind usart_rx: synchronised handshake capture into a show-ahead byte FIFO.
// Optional registered RTS flow control when USART_RX_BUFFER_FLOW_EN is defined.
module usart_rx_buffer #(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned RTS_THRESHOLD = 12
) (
    input  logic                  comm_clock,
    input  logic                  reset_n,
    input  logic                  rx_available,
    input  logic [7:0]            rx_data,
    input  logic                  rx_error,
    output logic                  rx_acknowledge,
    input  logic                  read_strobe,
    output logic [7:0]            data_out,
    output logic                  data_valid,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overrun,
    output logic                  frame_error,
    input  logic                  clear_errors,
    output logic                  rts_n
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FullCount = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [0:0] {StIdle, StAck} state_e;

    state_e                state_q, state_d;
    logic                  avail_meta_q, avail_s_q;
    logic [7:0]            mem [Depth];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic                  frame_error_q, frame_error_d;
    logic                  capture, push, pop;

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            avail_meta_q <= 1'b0;
            avail_s_q    <= 1'b0;
        end else begin
            avail_meta_q <= rx_available;
            avail_s_q    <= avail_meta_q;
        end
    end

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // One capture per handshake: only IDLE samples the byte, ACK waits for avail_s to fall.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (avail_s_q) begin
                    capture = 1'b1;
                    state_d = StAck;
                end
            end
            StAck: begin
                if (!avail_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_acknowledge = (state_q == StAck);

    assign pop  = read_strobe && (count_q != '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push = capture && ((count_q != FullCount) || pop);

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Set beats clear when both happen in the same cycle.
    assign overrun_d     = (overrun_q && !clear_errors) || (capture && !push);
    assign frame_error_d = (frame_error_q && !clear_errors) || (capture && rx_error);

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overrun_q     <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q       <= count_d;
            overrun_q     <= overrun_d;
            frame_error_q <= frame_error_d;
        end
    end

    always_ff @(posedge comm_clock) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    assign data_valid  = (count_q != '0);
    assign data_out    = data_valid ? mem[rd_ptr_q] : 8'h00;
    assign count       = count_q;
    assign overrun     = overrun_q;
    assign frame_error = frame_error_q;

`ifdef USART_RX_BUFFER_FLOW_EN
    localparam logic [DEPTH_LOG2:0] RtsLevel = RTS_THRESHOLD[DEPTH_LOG2:0];

    logic rts_q;

    always_ff @(posedge comm_clock or negedge reset_n) begin
        if (!reset_n) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= (count_d >= RtsLevel);
        end
    end

    assign rts_n = rts_q;
`else
    assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_usart_rx_buffer.sv
// Directed bench for usart_rx_buffer: handshake latency, FIFO order, overrun, errors, reset, RTS.
module tb_usart_rx_buffer;

    logic       comm_clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_available = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_error = 1'b0;
    logic       rx_acknowledge;
    logic       read_strobe = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic [4:0] count;
    logic       overrun;
    logic       frame_error;
    logic       clear_errors = 1'b0;
    logic       rts_n;

    int tests = 0;
    int fails = 0;

    usart_rx_buffer #(
        .DEPTH_LOG2   (4),
        .RTS_THRESHOLD(12)
    ) dut (
        .comm_clock    (comm_clock),
        .reset_n       (reset_n),
        .rx_available  (rx_available),
        .rx_data       (rx_data),
        .rx_error      (rx_error),
        .rx_acknowledge(rx_acknowledge),
        .read_strobe   (read_strobe),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .count         (count),
        .overrun       (overrun),
        .frame_error   (frame_error),
        .clear_errors  (clear_errors),
        .rts_n         (rts_n)
    );

    always #5 comm_clock = ~comm_clock;

    task automatic tick();
        @(posedge comm_clock);
        #1;
    endtask

    task automatic do_reset();
        rx_available = 1'b0;
        rx_data      = 8'h00;
        rx_error     = 1'b0;
        read_strobe  = 1'b0;
        clear_errors = 1'b0;
        reset_n      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_ack(input logic level);
        int n = 0;
        while (rx_acknowledge !== level && n < 20) begin
            tick();
            n++;
        end
        if (rx_acknowledge !== level) begin
            tests++;
            fails++;
            $display("FAIL handshake_timeout: rx_acknowledge=%b, wanted %b", rx_acknowledge, level);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic err);
        rx_data      = d;
        rx_error     = err;
        rx_available = 1'b1;
        wait_ack(1'b1);
        rx_available = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic pop_one();
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (rx_acknowledge !== 1'b0 || data_valid !== 1'b0 || count !== 5'd0 ||
            overrun !== 1'b0 || frame_error !== 1'b0 || data_out !== 8'h00 || rts_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ack=%b dv=%b cnt=%0d ovr=%b fe=%b dout=%h rts=%b, wanted all 0",
                     rx_acknowledge, data_valid, count, overrun, frame_error, data_out, rts_n);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        rx_data      = 8'hA5;
        rx_error     = 1'b0;
        rx_available = 1'b1;
        tick();
        tick();
        tests++;
        if (rx_acknowledge !== 1'b0 || count !== 5'd0) begin
            fails++;
            $display("FAIL single_early: ack=%b cnt=%0d, wanted 0 0", rx_acknowledge, count);
        end
        tick();
        tests++;
        if (rx_acknowledge !== 1'b1 || data_valid !== 1'b1 || data_out !== 8'hA5 || count !== 5'd1) begin
            fails++;
            $display("FAIL single_capture: ack=%b dv=%b dout=%h cnt=%0d, wanted 1 1 a5 1",
                     rx_acknowledge, data_valid, data_out, count);
        end
        // Holding avail must not produce a second capture.
        tick();
        tick();
        rx_available = 1'b0;
        tick();
        tick();
        tests++;
        if (rx_acknowledge !== 1'b1 || count !== 5'd1) begin
            fails++;
            $display("FAIL single_ack_hold: ack=%b cnt=%0d, wanted 1 1", rx_acknowledge, count);
        end
        tick();
        tests++;
        if (rx_acknowledge !== 1'b0) begin
            fails++;
            $display("FAIL single_ack_drop: ack=%b, wanted 0", rx_acknowledge);
        end
        pop_one();
        tests++;
        if (data_valid !== 1'b0 || count !== 5'd0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL single_pop: dv=%b cnt=%0d dout=%h, wanted 0 0 00", data_valid, count, data_out);
        end
        pop_one();
        tests++;
        if (count !== 5'd0 || overrun !== 1'b0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL empty_pop: cnt=%0d ovr=%b dv=%b, wanted 0 0 0", count, overrun, data_valid);
        end
    endtask

    task automatic test_fill_overrun();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b = 8'(i);
            send_byte(b, 1'b0);
        end
        tests++;
        if (count !== 5'd16 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL fill_full: cnt=%0d ovr=%b, wanted 16 1", count, overrun);
        end
        for (int i = 0; i < 16; i++) begin
            b = 8'(i);
            tests++;
            if (data_out !== b || data_valid !== 1'b1) begin
                fails++;
                $display("FAIL fill_order[%0d]: dout=%h dv=%b, wanted %h 1", i, data_out, data_valid, b);
            end
            pop_one();
        end
        tests++;
        if (data_valid !== 1'b0 || count !== 5'd0 || overrun !== 1'b1) begin
            fails++;
            $display("FAIL fill_drained: dv=%b cnt=%0d ovr=%b, wanted 0 0 1", data_valid, count, overrun);
        end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL overrun_clear: ovr=%b, wanted 0", overrun);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            b = 8'h80 + 8'(i);
            send_byte(b, 1'b0);
        end
        rx_data      = 8'h55;
        rx_error     = 1'b0;
        rx_available = 1'b1;
        tick();
        tick();
        read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
        tests++;
        if (count !== 5'd16 || overrun !== 1'b0 || rx_acknowledge !== 1'b1 || data_out !== 8'h81) begin
            fails++;
            $display("FAIL full_push_pop: cnt=%0d ovr=%b ack=%b dout=%h, wanted 16 0 1 81",
                     count, overrun, rx_acknowledge, data_out);
        end
        rx_available = 1'b0;
        wait_ack(1'b0);
        for (int i = 0; i < 15; i++) pop_one();
        tests++;
        if (count !== 5'd1 || data_out !== 8'h55) begin
            fails++;
            $display("FAIL full_last_out: cnt=%0d dout=%h, wanted 1 55", count, data_out);
        end
    endtask

    task automatic test_error_flag();
        do_reset();
        send_byte(8'h3C, 1'b1);
        tests++;
        if (count !== 5'd1 || data_out !== 8'h3C || frame_error !== 1'b1 || overrun !== 1'b0) begin
            fails++;
            $display("FAIL err_capture: cnt=%0d dout=%h fe=%b ovr=%b, wanted 1 3c 1 0",
                     count, data_out, frame_error, overrun);
        end
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        tests++;
        if (frame_error !== 1'b0) begin
            fails++;
            $display("FAIL err_clear: fe=%b, wanted 0", frame_error);
        end
        rx_data      = 8'h77;
        rx_error     = 1'b1;
        rx_available = 1'b1;
        tick();
        tick();
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        tests++;
        if (frame_error !== 1'b1 || count !== 5'd2) begin
            fails++;
            $display("FAIL err_set_wins: fe=%b cnt=%0d, wanted 1 2", frame_error, count);
        end
        rx_available = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic test_reset_mid_ack();
        do_reset();
        rx_data      = 8'h9E;
        rx_error     = 1'b0;
        rx_available = 1'b1;
        tick();
        tick();
        tick();
        tests++;
        if (rx_acknowledge !== 1'b1 || count !== 5'd1) begin
            fails++;
            $display("FAIL mid_ack_setup: ack=%b cnt=%0d, wanted 1 1", rx_acknowledge, count);
        end
        reset_n = 1'b0;
        #2;
        tests++;
        if (rx_acknowledge !== 1'b0 || count !== 5'd0 || data_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_ack_reset: ack=%b cnt=%0d dv=%b, wanted 0 0 0",
                     rx_acknowledge, count, data_valid);
        end
        reset_n = 1'b1;
        tick();
        tick();
        tick();
        tests++;
        if (rx_acknowledge !== 1'b1 || count !== 5'd1 || data_out !== 8'h9E) begin
            fails++;
            $display("FAIL mid_ack_recapture: ack=%b cnt=%0d dout=%h, wanted 1 1 9e",
                     rx_acknowledge, count, data_out);
        end
        rx_available = 1'b0;
        wait_ack(1'b0);
    endtask

    task automatic test_flow();
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            b = 8'h40 + 8'(i);
            send_byte(b, 1'b0);
        end
        tests++;
        if (rts_n !== 1'b0 || count !== 5'd11) begin
            fails++;
            $display("FAIL flow_below: rts=%b cnt=%0d, wanted 0 11", rts_n, count);
        end
        rx_data      = 8'h4B;
        rx_available = 1'b1;
        tick();
        tick();
        tick();
`ifdef USART_RX_BUFFER_FLOW_EN
        tests++;
        if (rts_n !== 1'b1 || count !== 5'd12) begin
            fails++;
            $display("FAIL flow_at_threshold: rts=%b cnt=%0d, wanted 1 12", rts_n, count);
        end
`else
        tests++;
        if (rts_n !== 1'b0 || count !== 5'd12) begin
            fails++;
            $display("FAIL flow_disabled: rts=%b cnt=%0d, wanted 0 12", rts_n, count);
        end
`endif
        rx_available = 1'b0;
        wait_ack(1'b0);
        pop_one();
        tests++;
        if (rts_n !== 1'b0 || count !== 5'd11) begin
            fails++;
            $display("FAIL flow_release: rts=%b cnt=%0d, wanted 0 11", rts_n, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_overrun();
        test_full_push_pop();
        test_error_flag();
        test_reset_mid_ack();
        test_flow();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
